// File: rtl/sync_mem_pkg.sv
// Shared types and helpers for the self-clearing synchronous memory.
// The parity option is enabled with the SYNC_MEM_PARITY_EN macro.
package sync_mem_pkg;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} mem_state_t;

  localparam int PARITY_MAX_W = 32;

  // Even parity of a word, zero-extended to PARITY_MAX_W bits by the caller.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_mem_array.sv
// Bare word storage: one write port and one registered read port.
// With SYNC_MEM_PARITY_EN the MSB of each word is its parity bit.
module sync_mem_array
  import sync_mem_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] w_rd_mask;

`ifdef SYNC_MEM_PARITY_EN
  // Fault hook: forcing a bit here inverts the stored parity of that word.
  logic [DEPTH-1:0] w_par_inv;
  assign w_par_inv = '0;
  assign w_rd_mask = {w_par_inv[i_raddr], {(WORD_W-1){1'b0}}};
`else
  assign w_rd_mask = '0;
`endif

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr] ^ w_rd_mask;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_mem_ctrl.sv
// Self-clearing synchronous single-port RAM: clear FSM, access qualification,
// rvalid/perr generation. Parity storage/checking via SYNC_MEM_PARITY_EN.
module sync_mem_ctrl
  import sync_mem_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              perr
);

`ifdef SYNC_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // Valid/ready contract: there is no back-pressure. An access is accepted
  // only in IDLE with cs_n=0, clr=0, rst=0; a read returns rdata with a
  // one-cycle rvalid exactly one cycle later. Everything else is dropped.
  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_rvalid;
  logic              w_busy;
  logic              w_acc;
  logic              w_wr;
  logic              w_rd;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [MEM_W-1:0]  w_wr_word;
  logic [MEM_W-1:0]  w_rd_word;

  assign w_busy = (r_state == CLEAR);
  assign w_acc  = !w_busy && !cs_n && !clr && !rst;
  assign w_wr   = w_acc && !we_n;
  assign w_rd   = w_acc && we_n;

  // Clearing owns the write port; nothing is written on a reset cycle.
  assign w_mem_we    = (w_busy && !rst) || w_wr;
  assign w_mem_waddr = w_busy ? r_cnt : addr;

`ifdef SYNC_MEM_PARITY_EN
  assign w_wr_word = w_busy ? '0 : {even_parity(PARITY_MAX_W'(wdata)), wdata};
  assign perr      = r_rvalid &&
                     (even_parity(PARITY_MAX_W'(w_rd_word[DATA_W-1:0])) != w_rd_word[DATA_W]);
`else
  assign w_wr_word = w_busy ? '0 : wdata;
  assign perr      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      CLEAR: begin
        if (clr) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == {ADDR_W{1'b1}}) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CLEAR;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_rd;
    end
  end

  sync_mem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (MEM_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_wr_word),
    .i_re    (w_rd),
    .i_raddr (addr),
    .o_rdata (w_rd_word)
  );

  assign rdata  = w_rd_word[DATA_W-1:0];
  assign rvalid = r_rvalid;
  assign busy   = w_busy;

endmodule
